// File: rtl/sdram_wr_arb_pkg.sv
// Types shared by the SDRAM write arbiter and its mycore-level hookup.
package sdram_wr_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} arb_state_t;

  localparam int ARB_N_REQ = 2;
  localparam int SDRAM_AW  = 25;
  localparam int SDRAM_DW  = 32;

  // One requester's write beat, bundled for routing ADDRn/DINn/BEn as a unit
  typedef struct packed {
    logic [SDRAM_AW-1:0]   addr;
    logic [SDRAM_DW-1:0]   din;
    logic [SDRAM_DW/8-1:0] be;
  } sdram_wr_t;

endpackage

// File: rtl/sdram_wr_arb_toggle_sync.sv
// STAGES-deep bit synchronizer (STAGES cycles latency, 0 = combinational pass-through).
// No flow control; also reusable for the read-ready toggle.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] ff;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ff <= '0;
        end else begin
          ff[0] <= d;
          for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
      end

      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sdram_wr_arb.sv
// Two-requester arbiter for the SDRAM toggle write port; REQ->ACK >= 3+SYNC_STAGES cycles plus controller time.
// Requesters hold REQ until ACK; SDRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module sdram_wr_arb
  import sdram_wr_arb_pkg::*;
#(
  parameter int AW          = 25,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 CLK,
  input  logic                 RESn,
  input  logic                 LOCK,
  input  logic [ARB_N_REQ-1:0] REQ,
  input  logic [AW-1:0]        ADDR0,
  input  logic [AW-1:0]        ADDR1,
  input  logic [DW-1:0]        DIN0,
  input  logic [DW-1:0]        DIN1,
  input  logic [DW/8-1:0]      BE0,
  input  logic [DW/8-1:0]      BE1,
  output logic [ARB_N_REQ-1:0] ACK,
  output logic [ARB_N_REQ-1:0] GNT,
  output logic [AW-1:0]        SDRAM_WADDR,
  output logic [DW-1:0]        SDRAM_DIN,
  output logic [DW/8-1:0]      SDRAM_BE,
  output logic                 SDRAM_WE_REQ,
  input  logic                 SDRAM_WE_ACK,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int            TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_t           state, state_nxt;
  logic [TW-1:0]        timer;
  logic                 ack_sync;
  logic [ARB_N_REQ-1:0] elig;
  logic                 win;
  logic                 ack_match, tmo_hit;
  logic                 load, issue, done;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (CLK),
    .rst_n (RESn),
    .d     (SDRAM_WE_ACK),
    .q     (ack_sync)
  );

  // Nothing is eligible during the ACK cycle: the requester still holds REQ there
  assign elig      = {REQ[1] & ~LOCK, REQ[0]} & {ARB_N_REQ{~|ACK}};
  assign ack_match = (ack_sync == SDRAM_WE_REQ);
  assign tmo_hit   = (TIMEOUT > 0) && (timer == TMO_LAST);

`ifdef SDRAM_ARB_RR_EN
  logic rr_ptr;

  assign win = (&elig) ? rr_ptr : ~elig[0];

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn)     rr_ptr <= 1'b0;
    else if (done) rr_ptr <= ~GNT[1];
  end
`else
  assign win = ~elig[0];
`endif

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|elig) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_match || tmo_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = (state == IDLE) && (|elig);
    issue = (state == ISSUE);
    done  = (state == WAIT_ACK) && (ack_match || tmo_hit);
    BUSY  = (state != IDLE);
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      ACK          <= '0;
      GNT          <= '0;
      SDRAM_WADDR  <= '0;
      SDRAM_DIN    <= '0;
      SDRAM_BE     <= '0;
      SDRAM_WE_REQ <= 1'b0;
      ERR          <= 1'b0;
      timer        <= '0;
    end else begin
      ACK <= '0;
      if (load) begin
        GNT         <= win ? 2'b10 : 2'b01;
        SDRAM_WADDR <= win ? ADDR1 : ADDR0;
        SDRAM_DIN   <= win ? DIN1  : DIN0;
        SDRAM_BE    <= win ? BE1   : BE0;
      end
      if (issue) begin
        SDRAM_WE_REQ <= ~SDRAM_WE_REQ;
        timer        <= '0;
      end
      if (state == WAIT_ACK) begin
        if (done) begin
          ACK <= GNT;
          GNT <= '0;
          // Timed out: adopt the controller's parity so the next toggle is a real request
          if (!ack_match) begin
            ERR          <= 1'b1;
            SDRAM_WE_REQ <= ack_sync;
          end
        end else if (timer != '1) begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_wr_arb.sv
// Randomized directed bench for sdram_wr_arb with a toggle-handshake SDRAM controller model.
module tb_sdram_wr_arb;

  localparam int AW   = 25;
  localparam int DW   = 32;
  localparam int SYNC = 2;
  localparam int TMO  = 8;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          CLK, RESn, LOCK;
  logic [1:0]    REQ;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] DIN0, DIN1;
  logic [3:0]    BE0, BE1;
  logic [1:0]    ACK, GNT;
  logic [AW-1:0] SDRAM_WADDR;
  logic [DW-1:0] SDRAM_DIN;
  logic [3:0]    SDRAM_BE;
  logic          SDRAM_WE_REQ, SDRAM_WE_ACK, BUSY, ERR;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   ctl_delay = 0, ack_set_cyc = 0;
  bit   ctl_mute = 1'b0;
  logic exp_we = 1'b0, exp_err = 1'b0;
  bit   rr = 1'b0;

  logic [AW-1:0] st_addr [2];
  logic [DW-1:0] st_din  [2];
  logic [3:0]    st_be   [2];
  logic [1:0]    rq, eg;
  logic          lk, we0;
  int            bad;

  sdram_wr_arb #(.AW(AW), .DW(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESn(RESn), .LOCK(LOCK), .REQ(REQ),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DIN0(DIN0), .DIN1(DIN1), .BE0(BE0), .BE1(BE1),
    .ACK(ACK), .GNT(GNT), .SDRAM_WADDR(SDRAM_WADDR), .SDRAM_DIN(SDRAM_DIN),
    .SDRAM_BE(SDRAM_BE), .SDRAM_WE_REQ(SDRAM_WE_REQ), .SDRAM_WE_ACK(SDRAM_WE_ACK),
    .BUSY(BUSY), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Controller: answers a pending toggle ctl_delay cycles later, unless muted
  initial begin : ctl
    int cnt;
    cnt = 0;
    SDRAM_WE_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESn) begin
        SDRAM_WE_ACK = 1'b0;
        cnt = 0;
      end else if (!ctl_mute && SDRAM_WE_REQ !== SDRAM_WE_ACK) begin
        if (cnt >= ctl_delay) begin
          SDRAM_WE_ACK = SDRAM_WE_REQ;
          ack_set_cyc = cyc;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] exp_winner(input logic [1:0] req, input logic lock, input bit ptr);
    logic [1:0] e;
    e = req & {~lock, 1'b1};
    if (e == 2'b11) return (RR_EN && ptr) ? 2'b10 : 2'b01;
    return e;
  endfunction

  task automatic drive();
    ADDR0 = st_addr[0]; DIN0 = st_din[0]; BE0 = st_be[0];
    ADDR1 = st_addr[1]; DIN1 = st_din[1]; BE1 = st_be[1];
  endtask

  task automatic new_data(input int r);
    st_addr[r] = AW'($urandom);
    st_din[r]  = $urandom;
    st_be[r]   = 4'($urandom_range(1, 15));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   ACK, 0);
    chk({tag, "_gnt"},   GNT, 0);
    chk({tag, "_wereq"}, SDRAM_WE_REQ, 0);
    chk({tag, "_waddr"}, SDRAM_WADDR, 0);
    chk({tag, "_din"},   SDRAM_DIN, 0);
    chk({tag, "_be"},    SDRAM_BE, 0);
    chk({tag, "_busy"},  BUSY, 0);
    chk({tag, "_err"},   ERR, 0);
  endtask

  // Returns one cycle after the grant, i.e. at the start of WAIT_ACK
  task automatic wait_grant(input logic [1:0] g);
    for (int i = 0; i < 20 && GNT == 2'b00; i++) step();
    chk("gnt", GNT, g);
    chk("waddr", SDRAM_WADDR, st_addr[g[1]]);
    chk("din", SDRAM_DIN, st_din[g[1]]);
    chk("be", SDRAM_BE, st_be[g[1]]);
    chk("busy", BUSY, 1);
    step();
    exp_we = ~exp_we;
    chk("we_req_toggle", SDRAM_WE_REQ, exp_we);
  endtask

  task automatic wait_ack(input logic [1:0] a, input bit tmo);
    int t0;
    t0 = cyc;
    for (int i = 0; i < 30 && ACK == 2'b00; i++) step();
    chk("ack", ACK, a);
    chk("gnt_clear_on_ack", GNT, 0);
    if (tmo) begin
      chk("tmo_cycles", 64'(cyc - t0), TMO);
      exp_err = 1'b1;
      exp_we  = SDRAM_WE_ACK;
    end else begin
      chk("ack_after_sync", 64'(cyc - ack_set_cyc), SYNC + 1);
    end
    chk("err", ERR, exp_err);
    chk("we_req_parity", SDRAM_WE_REQ, exp_we);
    rr = ~a[1];
    step();
    chk("idle_gap_gnt", GNT, 0);
    chk("ack_one_cycle", ACK, 0);
  endtask

  initial begin
    RESn = 1'b0; LOCK = 1'b0; REQ = 2'b00;
    for (int r = 0; r < 2; r++) begin st_addr[r] = '0; st_din[r] = '0; st_be[r] = '0; end
    drive();
    #12;
    chk_all_zero("reset");
    @(negedge CLK);
    RESn = 1'b1;
    step();

    // Single write from requester 0
    st_addr[0] = 25'h000100; st_din[0] = 32'hDEADBEEF; st_be[0] = 4'hF;
    drive();
    ctl_delay = 0;
    REQ = 2'b01;
    wait_grant(2'b01);
    wait_ack(2'b01, 1'b0);
    REQ = 2'b00;

    // Random mixes of requests, LOCK and controller latency
    for (int k = 0; k < 30; k++) begin
      new_data(0); new_data(1); drive();
      ctl_delay = $urandom_range(0, 3);
      rq = 2'($urandom_range(1, 3));
      lk = 1'($urandom_range(0, 1));
      if (lk && rq == 2'b10) lk = 1'b0;
      eg = exp_winner(rq, lk, rr);
      REQ = rq; LOCK = lk;
      wait_grant(eg);
      wait_ack(eg, 1'b0);
      REQ = 2'b00; LOCK = 1'b0;
    end

    // Both requesters held across four writes
    new_data(0); new_data(1); drive();
    REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ctl_delay = $urandom_range(0, 3);
      eg = exp_winner(2'b11, 1'b0, rr);
      wait_grant(eg);
      wait_ack(eg, 1'b0);
      new_data(int'(eg[1])); drive();
    end
    REQ = 2'b00;
    step();

    // LOCK blocks requester 1 entirely, release grants within 2 cycles
    new_data(1); drive();
    LOCK = 1'b1; REQ = 2'b10;
    we0 = SDRAM_WE_REQ; bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (GNT !== 2'b00 || SDRAM_WE_REQ !== we0 || BUSY !== 1'b0) bad++;
    end
    chk("lock_blocks", 64'(bad), 0);
    LOCK = 1'b0;
    for (int i = 0; i < 2 && GNT == 2'b00; i++) step();
    chk("lock_release_gnt", GNT, 2'b10);
    wait_grant(2'b10);
    wait_ack(2'b10, 1'b0);
    REQ = 2'b00;

    // LOCK rises while requester 1 waits for its ack
    ctl_delay = 3;
    new_data(0); new_data(1); drive();
    REQ = 2'b10;
    wait_grant(2'b10);
    LOCK = 1'b1; REQ = 2'b11;
    wait_ack(2'b10, 1'b0);
    eg = exp_winner(2'b11, 1'b1, rr);
    wait_grant(eg);
    wait_ack(eg, 1'b0);
    REQ = 2'b00; LOCK = 1'b0;

    // Controller never answers: timeout, then a normal write
    ctl_mute = 1'b1;
    new_data(0); drive();
    REQ = 2'b01;
    wait_grant(2'b01);
    wait_ack(2'b01, 1'b1);
    REQ = 2'b00;
    ctl_mute = 1'b0;
    ctl_delay = 1;
    new_data(1); drive();
    REQ = 2'b10;
    wait_grant(2'b10);
    wait_ack(2'b10, 1'b0);
    REQ = 2'b00;

    // Async reset between edges while waiting for an ack
    ctl_mute = 1'b1;
    new_data(0); drive();
    REQ = 2'b01;
    wait_grant(2'b01);
    step();
    #2;
    RESn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_we = 1'b0; exp_err = 1'b0; rr = 1'b0;
    REQ = 2'b00;
    ctl_mute = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESn = 1'b1;
    step();
    ctl_delay = 0;
    new_data(0); drive();
    REQ = 2'b01;
    wait_grant(2'b01);
    wait_ack(2'b01, 1'b0);
    REQ = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_wr_arb.md
Name: sdram_wr_arb

Overview:
- Shares the single SDRAM controller write port between two requesters: ROM/BIOS loader (requester 0) and memif_sdram CPU write path (requester 1).
- Replaces the download-gated mux. Accepts level-valid requests, issues toggle-style we_req to sdram, waits for the toggled we_ack, then pulses a per-requester ACK.
- Sits in mycore between the loader/memif_sdram and sdram.

Parameters:
- AW, 25, SDRAM byte address width.
- DW, 32, write data width; BE width is DW/8.
- SYNC_STAGES, 2, flops on SDRAM_WE_ACK (0 = controller is on CLK, no sync).
- TIMEOUT, 255, CLK cycles in WAIT_ACK before ERR; 0 disables.

Ports:
- CLK  in  1  arbiter clock.
- RESn  in  1  asynchronous active-low reset.
- LOCK  in  1  loader-exclusive mode (ioctl download active); requester 1 never granted.
- REQ  in  2  per-requester write valid; held until ACK.
- ADDR0/ADDR1  in  AW  write byte address.
- DIN0/DIN1  in  DW  write data.
- BE0/BE1  in  DW/8  byte enables (active high).
- ACK  out  2  one-cycle pulse per requester on completion.
- GNT  out  2  one-hot current owner; 0 when idle.
- SDRAM_WADDR  out  AW  registered address.
- SDRAM_DIN  out  DW  registered data.
- SDRAM_BE  out  DW/8  registered byte enables.
- SDRAM_WE_REQ  out  1  toggle; each edge is one write.
- SDRAM_WE_ACK  in  1  toggle from controller; equals WE_REQ when done.
- BUSY  out  1  high in ISSUE/WAIT_ACK.
- ERR  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset (async, RESn=0): state IDLE; ACK=0, GNT=0, SDRAM_WE_REQ=0, SDRAM_WADDR/DIN/BE=0, BUSY=0, ERR=0, timer=0, RR pointer=0, ack-sync flops=0.
- States: IDLE -> ISSUE -> WAIT_ACK -> IDLE.
- IDLE: pick a winner among eligible REQ bits. REQ[1] is ineligible when LOCK=1. Default is fixed priority, requester 0 first. On a winner: register its ADDR/DIN/BE, set GNT, go to ISSUE.
- ISSUE (1 cycle): toggle SDRAM_WE_REQ, clear timer, go to WAIT_ACK.
- WAIT_ACK: when synced ack equals SDRAM_WE_REQ, pulse ACK[owner] for 1 cycle, clear GNT, go to IDLE.
  - Minimum latency REQ rise -> ACK pulse = 3 + SYNC_STAGES cycles, plus controller time.
- Requester must hold REQ/ADDR/DIN/BE until ACK. The arbiter samples them only in IDLE.
- REQ dropped while owned: the transaction still completes and ACK still pulses. The requester must ignore it.
- LOCK rising while requester 1 owns: the current write completes. Requester 1 is then blocked from the next IDLE.
- Back-to-back: an ACK cycle and the next grant never overlap. A new grant earliest 1 cycle after the ACK pulse (IDLE cycle).
- Timeout (TIMEOUT>0): timer increments in WAIT_ACK and saturates. At TIMEOUT: set ERR, pulse ACK[owner], go to IDLE, and set SDRAM_WE_REQ to the synced ack value to resync parity.
- Ack sync: SYNC_STAGES-flop synchronizer; comparison uses the last stage only.
- Reset mid-WAIT_ACK: the arbiter drops to IDLE immediately. The system must reset sdram in the same event, since toggle parity restarts at 0.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin when both REQ are eligible. The RR pointer flips to the other requester after each ACK. LOCK still overrides.
- Undefined: fixed priority, requester 0 wins. The RR pointer logic is absent.

Decomposition:
- Shared core_pkg gains:
  - typedef arb_state_t {IDLE, ISSUE, WAIT_ACK};
  - localparam ARB_N_REQ=2;
  - typedef sdram_wr_t struct {addr, din, be}, used for ADDRn/DINn/BEn bundling at the mycore level.
- One sub-module: toggle_sync (SYNC_STAGES-deep bit synchronizer), reusable for the read-ready path.

Test Plan:
- Single write, requester 0: REQ=01, ADDR0=0x000100, DIN0=0xDEADBEEF, BE0=F. Expect the SDRAM outputs to carry those values, WE_REQ 0->1, then ACK=01 exactly 1 cycle after the model returns WE_ACK=1 (after sync).
- Contention, fixed priority: REQ=11 held for 4 writes. Expect grant order 0,0,0,0 and requester 1 starved. With SDRAM_ARB_RR_EN: expect 0,1,0,1.
- LOCK: LOCK=1, REQ=10 for 100 cycles. Expect GNT=00, no WE_REQ toggle. Drop LOCK: grant to 1 within 2 cycles.
- LOCK rises while requester 1 is in WAIT_ACK. Expect its ACK still pulses and the next grant goes to 0 only.
- Timeout: TIMEOUT=8, model never acks. Expect ERR=1 and ACK pulse 8 cycles into WAIT_ACK, WE_REQ equal to the synced ack, and the next request handled normally.
- Async reset: assert RESn=0 mid-WAIT_ACK between clock edges. Expect all outputs 0 before the next edge, and the first post-reset write toggles WE_REQ 0->1.
